// File: rtl/alu_shift_seq_pkg.sv
// Shared definitions for the shift/rotate execute units.
// Op codes, FSM state codes and default widths.
package alu_shift_seq_pkg;

   localparam int ALU_WIDTH = 8;
   localparam int ALU_CNT_W = 3;

   typedef enum logic [1:0] {
      OP_SHL = 2'b00,
      OP_SHR = 2'b01,
      OP_ROL = 2'b10,
      OP_ROR = 2'b11
   } alu_op_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_shift_seq_if.sv
// Request/response bundle of the sequential shift unit.
// master drives requests, slave is the execute unit.
interface alu_shift_seq_if
   import alu_shift_seq_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = ALU_CNT_W
) ();

   logic             start_i;
   logic [1:0]       ALUOp_i;
   logic [WIDTH-1:0] rs_i;
   logic [CNT_W-1:0] count_i;
   logic             flush_i;
   logic             ready_o;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] res_o;
   logic             cout_o;

   modport master (
      output start_i, ALUOp_i, rs_i, count_i, flush_i,
      input  ready_o, busy_o, done_o, res_o, cout_o
   );

   modport slave (
      input  start_i, ALUOp_i, rs_i, count_i, flush_i,
      output ready_o, busy_o, done_o, res_o, cout_o
   );

endinterface

// File: rtl/alu_shift_seq_shift_step.sv
// One-bit shift/rotate of the working value.
// Carry is the bit pushed out; rotates never carry.
module alu_shift_seq_shift_step
   import alu_shift_seq_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  alu_op_e          op_i,
   input  logic [WIDTH-1:0] res_i,
   output logic [WIDTH-1:0] res_o,
   output logic             cout_o
);

   // single step per op
   always_comb begin
      res_o  = res_i;
      cout_o = 1'b0;
      unique case (op_i)
         OP_SHL: begin
            cout_o = res_i[WIDTH-1];
            res_o  = {res_i[WIDTH-2:0], 1'b0};
         end
         OP_SHR: begin
            cout_o = res_i[0];
            res_o  = {1'b0, res_i[WIDTH-1:1]};
         end
         OP_ROL: res_o = {res_i[WIDTH-2:0], res_i[WIDTH-1]};
         OP_ROR: res_o = {res_i[0], res_i[WIDTH-1:1]};
      endcase
   end

endmodule

// File: rtl/alu_shift_seq.sv
// Sequential shift/rotate unit, one bit position per clock.
// Start/done handshake, flush abort, results held until next accept.
module alu_shift_seq
   import alu_shift_seq_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = ALU_CNT_W
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   alu_shift_seq_if.slave bus
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   alu_op_e          op_q, op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;

   logic [WIDTH-1:0] step_res;
   logic             step_cout;
   logic             ready;
   logic             accept;

   alu_shift_seq_shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op_i   (op_q),
      .res_i  (res_q),
      .res_o  (step_res),
      .cout_o (step_cout)
   );

   assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign accept = bus.start_i && ready && !bus.flush_i;

   // next state: flush wins over accept and over finishing a shift
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      res_d   = res_q;
      cout_d  = cout_q;
      if (bus.flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (accept) begin
         op_d    = alu_op_e'(bus.ALUOp_i);
         res_d   = bus.rs_i;
         cout_d  = 1'b0;
         cnt_d   = bus.count_i;
         state_d = (bus.count_i == '0) ? ST_DONE : ST_SHIFT;
      end else begin
         case (state_q)
            ST_SHIFT: begin
               res_d  = step_res;
               cout_d = step_cout;
               cnt_d  = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_SHL;
         res_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.ready_o = ready;
   assign bus.busy_o  = (state_q == ST_SHIFT);
   assign bus.done_o  = (state_q == ST_DONE);
   assign bus.res_o   = res_q;
   assign bus.cout_o  = cout_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq.
// Directed cases plus random sweep against a whole-word model.
module tb_alu_shift_seq;
   import alu_shift_seq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_shift_seq_if bus ();

   alu_shift_seq dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // whole-word reference: shift the operand by n in one go
   function automatic void model(input logic [1:0] op, input logic [7:0] rs,
                                 input int n, output logic [7:0] r, output logic c);
      logic [15:0] w;
      r = 8'h00;
      c = 1'b0;
      case (op)
         2'd0: begin w = {8'h00, rs} << n; r = w[7:0];  c = w[8]; end
         2'd1: begin w = {rs, 8'h00} >> n; r = w[15:8]; c = w[7]; end
         2'd2: begin w = {rs, rs} << n;    r = w[15:8]; end
         default: begin w = {rs, rs} >> n; r = w[7:0]; end
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input logic [7:0] rs, input int n);
      bus.start_i = 1'b1;
      bus.ALUOp_i = op;
      bus.rs_i    = rs;
      bus.count_i = n[2:0];
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.ALUOp_i = 2'($urandom);
      bus.rs_i    = 8'($urandom);
      bus.count_i = 3'($urandom);
   endtask

   task automatic wait_done(output int k, output bit ok);
      k  = 0;
      ok = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_o) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic check_done(input string nm, input int n,
                             input logic [7:0] er, input logic ec);
      int k;
      bit ok;
      wait_done(k, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s timeout: no done_o within 40 cycles", nm);
      end else begin
         if (k !== n) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", nm, k, n);
         end
         checks++;
         if (bus.res_o !== er) begin
            errors++;
            $display("FAIL %s res got %h exp %h", nm, bus.res_o, er);
         end
         checks++;
         if (bus.cout_o !== ec) begin
            errors++;
            $display("FAIL %s cout got %b exp %b", nm, bus.cout_o, ec);
         end
      end
   endtask

   task automatic run_op(input string nm, input logic [1:0] op, input logic [7:0] rs,
                         input int n, input logic [7:0] er, input logic ec);
      issue(op, rs, n);
      check_done(nm, n, er, ec);
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string nm);
      checks++;
      if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
         errors++;
         $display("FAIL %s idle got r/b/d %b%b%b exp 100", nm,
                  bus.ready_o, bus.busy_o, bus.done_o);
      end
   endtask

   task automatic no_done_for(input string nm, input int cyc);
      int seen;
      seen = 0;
      repeat (cyc) begin
         @(negedge clk);
         if (bus.done_o) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL %s stray done got %0d pulses exp 0", nm, seen);
      end
   endtask

   task automatic test_reset();
      #12;
      check_idle("reset");
      checks++;
      if (bus.res_o !== 8'h00 || bus.cout_o !== 1'b0) begin
         errors++;
         $display("FAIL reset res/cout got %h/%b exp 00/0", bus.res_o, bus.cout_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      run_op("shl_b4", OP_SHL, 8'hB4, 3, 8'hA0, 1'b1);
      run_op("shr_2d", OP_SHR, 8'h2D, 2, 8'h0B, 1'b0);
      run_op("shr_2e", OP_SHR, 8'h2E, 2, 8'h0B, 1'b1);
      run_op("rol_81", OP_ROL, 8'h81, 1, 8'h03, 1'b0);
      run_op("ror_81", OP_ROR, 8'h81, 7, 8'h03, 1'b0);
   endtask

   task automatic test_zero_count();
      for (int op = 0; op < 4; op++) begin
         run_op($sformatf("zero_op%0d", op), 2'(op), 8'h5A, 0, 8'h5A, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] r;
      logic c;
      issue(OP_ROL, 8'h3C, 2);
      model(OP_ROL, 8'h3C, 2, r, c);
      check_done("b2b_a", 2, r, c);
      checks++;
      if (bus.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b ready_in_done got %b exp 1", bus.ready_o);
      end
      issue(OP_SHR, 8'h96, 4);
      model(OP_SHR, 8'h96, 4, r, c);
      check_done("b2b_b", 4, r, c);
      issue(OP_SHL, 8'hE7, 0);
      check_done("b2b_c", 0, 8'hE7, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_idle("b2b_after");
      @(posedge clk);
      #1;
   endtask

   task automatic test_flush();
      logic [7:0] r0;
      int dl [2] = '{0, 2};
      foreach (dl[i]) begin
         issue(OP_SHL, 8'hF1, 3);
         repeat (dl[i]) begin
            @(posedge clk);
            #1;
         end
         bus.flush_i = 1'b1;
         bus.start_i = 1'b1;
         @(posedge clk);
         #1;
         bus.flush_i = 1'b0;
         bus.start_i = 1'b0;
         @(negedge clk);
         check_idle($sformatf("flush_d%0d", dl[i]));
         r0 = bus.res_o;
         checks++;
         if ($isunknown({bus.res_o, bus.cout_o})) begin
            errors++;
            $display("FAIL flush_d%0d res/cout X got %h/%b", dl[i], bus.res_o, bus.cout_o);
         end
         no_done_for($sformatf("flush_d%0d", dl[i]), 8);
         checks++;
         if (bus.res_o !== r0) begin
            errors++;
            $display("FAIL flush_d%0d res unstable got %h exp %h", dl[i], bus.res_o, r0);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid();
      issue(OP_ROR, 8'h77, 7);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle("rst_mid");
      checks++;
      if (bus.res_o !== 8'h00 || bus.cout_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid res/cout got %h/%b exp 00/0", bus.res_o, bus.cout_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      no_done_for("rst_mid", 10);
      @(posedge clk);
      #1;
   endtask

   task automatic test_busy_start();
      logic [7:0] r;
      logic c;
      int k;
      bit ok;
      issue(OP_SHL, 8'hC3, 6);
      model(OP_SHL, 8'hC3, 6, r, c);
      repeat (3) begin
         checks++;
         if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_start busy/ready got %b/%b exp 1/0", bus.busy_o, bus.ready_o);
         end
         bus.start_i = 1'b1;
         bus.ALUOp_i = 2'($urandom);
         bus.rs_i    = 8'($urandom);
         bus.count_i = 3'($urandom);
         @(posedge clk);
         #1;
      end
      bus.start_i = 1'b0;
      check_done("busy_start", 3, r, c);
      wait_done(k, ok);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_idle("busy_start_end");
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [1:0] op;
      logic [7:0] rs;
      logic [7:0] r;
      logic c;
      int n;
      for (int i = 0; i < 200; i++) begin
         op = 2'($urandom);
         rs = 8'($urandom);
         n  = $urandom_range(0, 7);
         model(op, rs, n, r, c);
         run_op($sformatf("rnd%0d_op%0d_n%0d", i, op, n), op, rs, n, r, c);
      end
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.ALUOp_i = 2'b00;
      bus.rs_i    = 8'h00;
      bus.count_i = 3'd0;
      bus.flush_i = 1'b0;
      test_reset();
      test_directed();
      test_zero_count();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_busy_start();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
